instr_encoder: RTL

- Streaming instruction assembler: the inverse of the datapath immediate extraction.
- Accepts decoded fields (type, registers, funct3, 64-bit immediate) and packs them into 32-bit RV64 LD (I-type) or BEQ (B-type) words.
- Each word is tagged with a sequential instruction-memory word address and handed to the imem loader through a 2-entry output buffer.
- Immediates that the decoder-side sign extension could not reproduce are rejected and flagged.

---
 rtl/instr_encoder.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// Streaming RV64 LD/BEQ assembler with address tagging and a 2-entry output buffer.
// Define INSTR_ENCODER_ROUNDTRIP_CHECK_EN to add the internal re-decode checker behind chk_fail.
`ifndef OP_B_TYPE
`define OP_B_TYPE 7'b1100011
`endif

module instr_encoder #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_is_branch,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [63:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err,
    output logic              addr_wrap,
    output logic              chk_fail
);

    localparam logic [6:0]        OP_I_TYPE = 7'b0000011;
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;

    // Legal only if the decoder's sign extension reproduces the full 64-bit value.
    function automatic logic fits_i(input logic signed [52:0] hi);
        return (&hi) || !(|hi);
    endfunction

    function automatic logic fits_b(input logic signed [51:0] hi, input logic lsb);
        return ((&hi) || !(|hi)) && !lsb;
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, OP_I_TYPE};
    endfunction

    // imm holds byte-offset bits [12:1]; bit 0 is always zero for a legal branch.
    function automatic logic [31:0] enc_b(input logic [12:1] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], `OP_B_TYPE};
    endfunction

    logic [1:0]        count;
    logic [31:0]       head_instr, tail_instr;
    logic [ADDR_W-1:0] head_addr, tail_addr;
    logic [ADDR_W-1:0] addr_cnt;
    logic [31:0]       word;
    logic              legal, accept, push, pop;

    always_comb begin
        word  = in_is_branch ? enc_b(in_imm[12:1], in_rs2, in_rs1, in_funct3)
                             : enc_i(in_imm[11:0], in_rs1, in_funct3, in_rd);
        legal = in_is_branch ? fits_b(in_imm[63:12], in_imm[0]) : fits_i(in_imm[63:11]);
    end

    // in_ready depends on the registered occupancy only, never on out_ready.
    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign accept    = in_valid && in_ready;
    assign push      = accept && legal;
    assign pop       = out_valid && out_ready;
    assign out_instr = head_instr;
    assign out_addr  = head_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count      <= 2'd0;
            head_instr <= '0;
            tail_instr <= '0;
            head_addr  <= '0;
            tail_addr  <= '0;
            addr_cnt   <= BASE;
            err        <= 1'b0;
            addr_wrap  <= 1'b0;
        end else if (clr) begin
            count      <= 2'd0;
            head_instr <= '0;
            tail_instr <= '0;
            head_addr  <= '0;
            tail_addr  <= '0;
            addr_cnt   <= BASE;
            err        <= 1'b0;
            addr_wrap  <= 1'b0;
        end else begin
            if (push) begin
                addr_cnt <= addr_cnt + ADDR_W'(1);
                if (addr_cnt == ADDR_MAX)
                    addr_wrap <= 1'b1;
            end
            if (accept && !legal)
                err <= 1'b1;
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head_instr <= word;
                        head_addr  <= addr_cnt;
                    end else begin
                        tail_instr <= word;
                        tail_addr  <= addr_cnt;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head_instr <= tail_instr;
                    head_addr  <= tail_addr;
                    count      <= count - 2'd1;
                end
                // Push implies occupancy below 2, so with a pop the new word becomes the head.
                2'b11: begin
                    head_instr <= word;
                    head_addr  <= addr_cnt;
                end
                default: ;
            endcase
        end
    end

`ifdef INSTR_ENCODER_ROUNDTRIP_CHECK_EN
    function automatic logic [63:0] dec_imm(input logic [31:0] w);
        if (w[6:0] == `OP_B_TYPE)
            return {{52{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
        return {{52{w[31]}}, w[31:20]};
    endfunction

    logic chk_fail_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            chk_fail_q <= 1'b0;
        else if (clr)
            chk_fail_q <= 1'b0;
        else if (push && (dec_imm(word) != in_imm))
            chk_fail_q <= 1'b1;
    end

    assign chk_fail = chk_fail_q;
`else
    assign chk_fail = 1'b0;
`endif

endmodule
